// File: rtl/sprite_wr_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_wr_if
//  Purpose  : CPU write port carrying sprite attribute updates into the
//             overlay engine's shadow bank.
//  Revision : 1.0
// ============================================================================
interface sprite_wr_if #(
    parameter int NUM_SPRITES = 4,
    parameter int COLOR_W     = 12,
    parameter int COORD_W     = 10
);
    localparam int ADDR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int DATA_W = 1 + COLOR_W + 2 * COORD_W;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface
`default_nettype wire

// File: rtl/sprite_overlay_engine.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_overlay_engine
//  Purpose  : Multi-sprite solid-colour overlay with per-frame atomic commit,
//             fixed-priority compositing and collision detection.
//  Revision : 1.0
// ============================================================================
module sprite_overlay_engine #(
    parameter int NUM_SPRITES = 4,
    parameter int COORD_W     = 10,
    parameter int CNT_W       = 11,
    parameter int COLOR_W     = 12,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32,
    parameter int V_VISIBLE   = 480
) (
    input  wire logic               pixel_clk,
    input  wire logic               reset,
    input  wire logic [CNT_W-1:0]   hcount,
    input  wire logic [CNT_W-1:0]   vcount,
    input  wire logic               blank,
    input  wire logic               hsync_in,
    input  wire logic               vsync_in,
    sprite_wr_if.slave              wr,
    input  wire logic [COLOR_W-1:0] bg_color,
    output logic      [COLOR_W-1:0] color,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    blank_out,
    output logic                    frame_tick,
    output logic                    collision
);
    localparam int ADDR_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam int DATA_W = 1 + COLOR_W + 2 * COORD_W;
    localparam int SUM_W  = ((COORD_W > CNT_W) ? COORD_W : CNT_W) + 1;

    localparam logic [ADDR_W:0]    c_num_slots = (ADDR_W + 1)'(NUM_SPRITES);
    localparam logic [SUM_W-1:0]   c_spr_w     = SUM_W'(SPR_W);
    localparam logic [SUM_W-1:0]   c_spr_h     = SUM_W'(SPR_H);
    localparam logic [CNT_W-1:0]   c_v_commit  = CNT_W'(V_VISIBLE);

    logic [DATA_W-1:0]      r_shadow   [NUM_SPRITES];
    logic [DATA_W-1:0]      r_active   [NUM_SPRITES];
    logic [COLOR_W-1:0]     r_color_s1 [NUM_SPRITES];
    logic [COLOR_W-1:0]     w_slot_color [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] w_hit;
    logic [NUM_SPRITES-1:0] r_hit_s1;
    logic                   r_blank_s1, r_hsync_s1, r_vsync_s1;
    logic                   r_acc;
    logic [COLOR_W-1:0]     w_mux;
    logic                   w_commit, w_wr_ok, w_multi_hit;
    logic [SUM_W-1:0]       w_h_ext, w_v_ext;

    assign w_commit = (vcount == c_v_commit) && (hcount == '0);
    assign w_wr_ok  = wr.wr_en && ({1'b0, wr.wr_addr} < c_num_slots);
    assign w_h_ext  = SUM_W'(hcount);
    assign w_v_ext  = SUM_W'(vcount);

    // Widened sums keep sprites near the coordinate limit from wrapping to 0.
    for (genvar gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
        logic [SUM_W-1:0] w_x, w_y;
        logic             w_en;
        assign w_x  = SUM_W'(r_active[gi][COORD_W-1:0]);
        assign w_y  = SUM_W'(r_active[gi][2*COORD_W-1:COORD_W]);
        assign w_en = r_active[gi][DATA_W-1];
        assign w_slot_color[gi] = r_active[gi][2*COORD_W +: COLOR_W];
        assign w_hit[gi] = w_en
                        && (w_h_ext >= w_x) && (w_h_ext < w_x + c_spr_w)
                        && (w_v_ext >= w_y) && (w_v_ext < w_y + c_spr_h);
    end

    // Clearing the lowest set bit leaves something only when two or more hit.
    assign w_multi_hit = |(w_hit & (w_hit - NUM_SPRITES'(1)));

    // Active bank copies the pre-edge shadow, so a commit-cycle write lands a frame later.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
            r_acc      <= 1'b0;
            collision  <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_shadow[wr.wr_addr] <= wr.wr_data;
            end
            frame_tick <= w_commit;
            if (w_commit) begin
                r_active  <= r_shadow;
                collision <= r_acc;
                r_acc     <= 1'b0;
            end else if (!blank && w_multi_hit) begin
                r_acc <= 1'b1;
            end
        end
    end

    always_comb begin
        w_mux = bg_color;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (r_hit_s1[i]) begin
                w_mux = r_color_s1[i];
            end
        end
        if (r_blank_s1) begin
            w_mux = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_color_s1[i] <= '0;
            end
            r_hit_s1   <= '0;
            r_blank_s1 <= 1'b0;
            r_hsync_s1 <= 1'b0;
            r_vsync_s1 <= 1'b0;
            color      <= '0;
            hsync      <= 1'b0;
            vsync      <= 1'b0;
            blank_out  <= 1'b0;
        end else begin
            r_color_s1 <= w_slot_color;
            r_hit_s1   <= w_hit;
            r_blank_s1 <= blank;
            r_hsync_s1 <= hsync_in;
            r_vsync_s1 <= vsync_in;
            color      <= w_mux;
            hsync      <= r_hsync_s1;
            vsync      <= r_vsync_s1;
            blank_out  <= r_blank_s1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sprite_overlay_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_overlay_engine
//  Purpose  : Directed, table-driven self-checking bench for the overlay engine.
//  Revision : 1.0
// ============================================================================
module tb_sprite_overlay_engine;
    localparam int NS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount, vcount;
    logic        blank, hsync_in, vsync_in;
    logic [11:0] bg_color;
    logic [11:0] color;
    logic        hsync, vsync, blank_out, frame_tick, collision;

    int checks = 0;
    int errors = 0;

    sprite_wr_if #(.NUM_SPRITES(NS), .COLOR_W(12), .COORD_W(10)) wr_bus ();

    sprite_overlay_engine #(.NUM_SPRITES(NS)) dut (
        .pixel_clk  (clk),
        .reset      (rst),
        .hcount     (hcount),
        .vcount     (vcount),
        .blank      (blank),
        .hsync_in   (hsync_in),
        .vsync_in   (vsync_in),
        .wr         (wr_bus),
        .bg_color   (bg_color),
        .color      (color),
        .hsync      (hsync),
        .vsync      (vsync),
        .blank_out  (blank_out),
        .frame_tick (frame_tick),
        .collision  (collision)
    );

    always #20 clk = ~clk;

    typedef struct {
        int          h;
        int          v;
        logic        blk;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        logic hs;
        logic vs;
        logic bl;
    } sync_t;

    vec_t  tab[$];
    sync_t hist[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] mk(input logic en, input logic [11:0] c, input int y, input int x);
        return {en, c, y[9:0], x[9:0]};
    endfunction

    task automatic wr(input int addr, input logic [32:0] d);
        @(negedge clk);
        wr_bus.wr_en   = 1'b1;
        wr_bus.wr_addr = addr[1:0];
        wr_bus.wr_data = d;
        @(negedge clk);
        wr_bus.wr_en   = 1'b0;
    endtask

    // Holds one pixel position for two edges, then samples the composited colour.
    task automatic probe(input int h, input int v, input logic blk, input logic [11:0] exp);
        @(negedge clk);
        hcount = h[10:0];
        vcount = v[10:0];
        blank  = blk;
        @(posedge clk);
        @(posedge clk);
        #1;
        check($sformatf("color@(%0d,%0d,b%0d)", h, v, blk), {20'b0, color}, {20'b0, exp});
    endtask

    task automatic run_table();
        foreach (tab[i]) probe(tab[i].h, tab[i].v, tab[i].blk, tab[i].exp);
        tab.delete();
    endtask

    task automatic commit(input logic do_wr, input int addr, input logic [32:0] d, input int exp_coll);
        @(negedge clk);
        hcount = 11'd0;
        vcount = 11'd480;
        blank  = 1'b1;
        wr_bus.wr_en   = do_wr;
        wr_bus.wr_addr = addr[1:0];
        wr_bus.wr_data = d;
        @(posedge clk);
        #1;
        check("frame_tick_pulse", {31'b0, frame_tick}, 32'd1);
        if (exp_coll >= 0) check("collision", {31'b0, collision}, exp_coll);
        @(negedge clk);
        wr_bus.wr_en = 1'b0;
        vcount = 11'd481;
        @(posedge clk);
        #1;
        check("frame_tick_low", {31'b0, frame_tick}, 32'd0);
    endtask

    initial begin
        int ticks;
        rst = 1'b1;
        hcount = 11'd100; vcount = 11'd50; blank = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1; bg_color = 12'h00F;
        wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_color", {20'b0, color}, 32'h0);
        check("rst_hsync", {31'b0, hsync}, 32'd0);
        check("rst_vsync", {31'b0, vsync}, 32'd0);
        check("rst_frame_tick", {31'b0, frame_tick}, 32'd0);
        check("rst_collision", {31'b0, collision}, 32'd0);
        @(negedge clk);
        rst = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;

        // Single sprite: not visible until the commit.
        wr(0, mk(1'b1, 12'hF00, 50, 100));
        probe(100, 50, 1'b0, 12'h00F);
        commit(1'b0, 0, '0, 0);
        tab.push_back('{100, 50, 1'b0, 12'hF00});
        tab.push_back('{131, 81, 1'b0, 12'hF00});
        tab.push_back('{132, 50, 1'b0, 12'h00F});
        tab.push_back('{99, 50, 1'b0, 12'h00F});
        tab.push_back('{100, 49, 1'b0, 12'h00F});
        tab.push_back('{100, 82, 1'b0, 12'h00F});
        tab.push_back('{100, 50, 1'b1, 12'h000});
        run_table();

        // Overlap, priority and collision.
        wr(1, mk(1'b1, 12'h0F0, 66, 116));
        commit(1'b0, 0, '0, 0);
        probe(120, 70, 1'b1, 12'h000);
        commit(1'b0, 0, '0, 0);
        tab.push_back('{120, 70, 1'b0, 12'hF00});
        tab.push_back('{140, 90, 1'b0, 12'h0F0});
        tab.push_back('{116, 66, 1'b0, 12'hF00});
        tab.push_back('{147, 97, 1'b0, 12'h0F0});
        tab.push_back('{148, 97, 1'b0, 12'h00F});
        run_table();
        commit(1'b0, 0, '0, 1);
        wr(1, mk(1'b1, 12'h0F0, 300, 300));
        commit(1'b0, 0, '0, 0);
        probe(120, 70, 1'b0, 12'hF00);
        probe(300, 300, 1'b0, 12'h0F0);
        commit(1'b0, 0, '0, 0);

        // Tear-free update and commit-cycle write.
        wr(0, mk(1'b1, 12'hF00, 50, 200));
        probe(100, 60, 1'b0, 12'hF00);
        probe(200, 60, 1'b0, 12'h00F);
        commit(1'b0, 0, '0, -1);
        probe(200, 60, 1'b0, 12'hF00);
        probe(100, 60, 1'b0, 12'h00F);
        commit(1'b1, 0, mk(1'b1, 12'hF00, 50, 400), -1);
        probe(200, 60, 1'b0, 12'hF00);
        probe(400, 60, 1'b0, 12'h00F);
        commit(1'b0, 0, '0, -1);
        probe(400, 60, 1'b0, 12'hF00);
        probe(200, 60, 1'b0, 12'h00F);

        // Screen-edge clipping and no coordinate wrap.
        wr(2, mk(1'b1, 12'hFFF, 470, 620));
        wr(1, mk(1'b1, 12'h0F0, 1000, 1000));
        commit(1'b0, 0, '0, -1);
        tab.push_back('{620, 470, 1'b0, 12'hFFF});
        tab.push_back('{639, 479, 1'b0, 12'hFFF});
        tab.push_back('{619, 470, 1'b0, 12'h00F});
        tab.push_back('{620, 469, 1'b0, 12'h00F});
        tab.push_back('{639, 479, 1'b1, 12'h000});
        tab.push_back('{0, 470, 1'b0, 12'h00F});
        tab.push_back('{620, 0, 1'b0, 12'h00F});
        tab.push_back('{1010, 1010, 1'b0, 12'h0F0});
        tab.push_back('{999, 1010, 1'b0, 12'h00F});
        run_table();

        // Sync/blank alignment and a single frame_tick across a commit.
        ticks = 0;
        hist.delete();
        for (int v = 478; v <= 482; v++) begin
            for (int h = 0; h < 8; h++) begin
                sync_t s;
                s.hs = 1'($urandom_range(0, 1));
                s.vs = 1'($urandom_range(0, 1));
                s.bl = 1'($urandom_range(0, 1));
                @(negedge clk);
                hcount = h[10:0]; vcount = v[10:0];
                hsync_in = s.hs; vsync_in = s.vs; blank = s.bl;
                hist.push_back(s);
                @(posedge clk);
                #1;
                if (frame_tick) ticks++;
                if (hist.size() >= 2) begin
                    check("align_hsync", {31'b0, hsync}, {31'b0, hist[hist.size()-2].hs});
                    check("align_vsync", {31'b0, vsync}, {31'b0, hist[hist.size()-2].vs});
                    check("align_blank", {31'b0, blank_out}, {31'b0, hist[hist.size()-2].bl});
                end
            end
        end
        check("ticks_per_frame", ticks, 32'd1);

        // Reset mid-line with sprites active.
        @(negedge clk);
        hcount = 11'd400; vcount = 11'd50; blank = 1'b0;
        hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_color", {20'b0, color}, 32'hF00);
        check("pre_rst_hsync", {31'b0, hsync}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_color", {20'b0, color}, 32'h0);
        check("mid_rst_hsync", {31'b0, hsync}, 32'd0);
        check("mid_rst_vsync", {31'b0, vsync}, 32'd0);
        check("mid_rst_blank", {31'b0, blank_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        probe(400, 50, 1'b0, 12'h00F);
        commit(1'b0, 0, '0, 0);
        probe(400, 50, 1'b0, 12'h00F);
        probe(620, 470, 1'b0, 12'h00F);
        wr(0, mk(1'b1, 12'hF00, 50, 400));
        wr(3, mk(1'b1, 12'hABC, 10, 10));
        probe(400, 50, 1'b0, 12'h00F);
        commit(1'b0, 0, '0, 0);
        probe(400, 50, 1'b0, 12'hF00);
        probe(10, 10, 1'b0, 12'h00F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
